// File: rtl/instr_pkg.sv
// Shared instrument encodings for the note scheduler: serial IDs, slot indices,
// payload widths and activity-flag bit positions.
package instr_pkg;

    localparam logic [2:0] ID_BASS = 3'b001;
    localparam logic [2:0] ID_DRUM = 3'b010;
    localparam logic [2:0] ID_GUIT = 3'b100;

    localparam int IX_BASS = 0;
    localparam int IX_DRUM = 1;
    localparam int IX_GUIT = 2;

    localparam int BASS_W    = 5;
    localparam int DRUM_W    = 4;
    localparam int GUIT_W    = 5;
    localparam int PAYLOAD_W = 5;

    localparam int INST_GUIT = 0;
    localparam int INST_BASS = 1;
    localparam int INST_FOOT = 2;

    typedef enum logic [1:0] {
        RR_BASS = 2'd0,
        RR_DRUM = 2'd1,
        RR_GUIT = 2'd2
    } rr_ptr_e;

    function automatic logic id_is_onehot(input logic [2:0] id);
        return (id == ID_BASS) || (id == ID_DRUM) || (id == ID_GUIT);
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: one-hot grant searched from the pointer,
// pointer moves past the winner whenever a grant is taken.
module rr_arbiter3
    import instr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] eligible_i,
    input  logic       advance_i,
    output logic [2:0] grant_o
);

    rr_ptr_e    ptr_q, ptr_d;
    logic [2:0] sum;
    logic [1:0] cand;
    logic       found;

    // Search order is ptr, ptr+1, ptr+2 modulo 3 (bass -> drum -> guitar -> bass).
    always_comb begin
        grant_o = 3'b000;
        ptr_d   = ptr_q;
        found   = 1'b0;
        sum     = 3'd0;
        cand    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            sum = 3'(ptr_q) + 3'(k);
            if (sum >= 3'd3) begin
                sum = sum - 3'd3;
            end
            cand = sum[1:0];
            if (!found && eligible_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                ptr_d         = (cand == 2'd2) ? RR_BASS : rr_ptr_e'(cand + 2'd1);
            end
        end
        if (!advance_i) begin
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= RR_BASS;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Latest-wins pending slots with per-instrument hold timers feeding the bass,
// drum and guitar actuator registers, at most one update per clock.
module note_scheduler
    import instr_pkg::*;
#(
    parameter int HOLD_CYCLES = 2_700_000,
    parameter int TIMER_W     = 22
) (
    input  logic       clk,
    input  logic       rst,
    // rx_valid is a one-cycle strobe with no backpressure: a byte is taken in
    // every cycle rx_valid is high, and rx_data is only meaningful then.
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [4:0] bass,
    output logic [3:0] drum,
    output logic       drum_foot,
    output logic [4:0] guitar,
    output logic [2:0] inst,
    output logic [2:0] apply_strobe,
    output logic       bad_id,
    output logic [7:0] drop_cnt
);

    localparam logic [TIMER_W-1:0] HOLD_LD = TIMER_W'(HOLD_CYCLES);

    logic [2:0]                    pend_flag_q, pend_flag_d;
    logic [2:0][PAYLOAD_W-1:0]     pend_data_q, pend_data_d;
    logic [2:0][TIMER_W-1:0]       timer_q, timer_d;
    logic [BASS_W-1:0]             bass_q, bass_d;
    logic [DRUM_W-1:0]             drum_q, drum_d;
    logic                          foot_q, foot_d;
    logic [GUIT_W-1:0]             guitar_q, guitar_d;
    logic [2:0]                    strobe_q;
    logic                          bad_id_q;
    logic [7:0]                    drop_q, drop_d;

    logic [2:0]           id;
    logic [PAYLOAD_W-1:0] payload;
    logic                 id_ok;
    logic [2:0]           accept;
    logic [2:0]           eligible;
    logic [2:0]           grant;
    logic                 overwrite;

    assign id      = rx_data[2:0];
    assign payload = rx_data[7:3];
    assign id_ok   = id_is_onehot(id);
    // ID bit position equals the slot index, so the ID itself is the accept mask.
    assign accept  = (rx_valid && id_ok) ? id : 3'b000;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            eligible[i] = pend_flag_q[i] && (timer_q[i] == '0);
        end
    end

    rr_arbiter3 u_arb (
        .clk        (clk),
        .rst        (rst),
        .eligible_i (eligible),
        .advance_i  (|eligible),
        .grant_o    (grant)
    );

    // A grant always consumes the value pending before this edge; a same-cycle
    // accept then re-arms the slot without counting as a drop.
    assign overwrite = |(accept & pend_flag_q & ~grant);

    always_comb begin
        pend_flag_d = pend_flag_q;
        pend_data_d = pend_data_q;
        timer_d     = timer_q;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                timer_d[i]     = HOLD_LD;
                pend_flag_d[i] = 1'b0;
            end else if (timer_q[i] != '0) begin
                timer_d[i] = timer_q[i] - TIMER_W'(1);
            end
            if (accept[i]) begin
                pend_flag_d[i] = 1'b1;
                pend_data_d[i] = payload;
            end
        end
        drop_d = drop_q;
        if (overwrite && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        bass_d   = grant[IX_BASS] ? pend_data_q[IX_BASS]               : bass_q;
        drum_d   = grant[IX_DRUM] ? pend_data_q[IX_DRUM][DRUM_W-1:0]   : drum_q;
        foot_d   = grant[IX_DRUM] ? pend_data_q[IX_DRUM][PAYLOAD_W-1]  : foot_q;
        guitar_d = grant[IX_GUIT] ? pend_data_q[IX_GUIT]               : guitar_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_flag_q <= '0;
            pend_data_q <= '0;
            timer_q     <= '0;
            bass_q      <= '0;
            drum_q      <= '0;
            foot_q      <= 1'b0;
            guitar_q    <= '0;
            strobe_q    <= 3'b000;
            bad_id_q    <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            pend_flag_q <= pend_flag_d;
            pend_data_q <= pend_data_d;
            timer_q     <= timer_d;
            bass_q      <= bass_d;
            drum_q      <= drum_d;
            foot_q      <= foot_d;
            guitar_q    <= guitar_d;
            strobe_q    <= grant;
            bad_id_q    <= rx_valid && !id_ok;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        inst            = 3'b000;
        inst[INST_GUIT] = |guitar_q;
        inst[INST_BASS] = |bass_q;
        inst[INST_FOOT] = foot_q;
    end

    assign bass         = bass_q;
    assign drum         = drum_q;
    assign drum_foot    = foot_q;
    assign guitar       = guitar_q;
    assign apply_strobe = strobe_q;
    assign bad_id       = bad_id_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with HOLD_CYCLES=4: a cycle-by-cycle vector
// table plus hand-built sequences for hold, round robin, saturation and reset.
module tb_note_scheduler;

    localparam int HOLD    = 4;
    localparam int TIMER_W = 8;

    localparam logic [2:0] B = 3'b001;
    localparam logic [2:0] D = 3'b010;
    localparam logic [2:0] G = 3'b100;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [4:0] bass;
    logic [3:0] drum;
    logic       drum_foot;
    logic [4:0] guitar;
    logic [2:0] inst;
    logic [2:0] apply_strobe;
    logic       bad_id;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic [4:0] e_bass;
        logic [3:0] e_drum;
        logic       e_foot;
        logic [4:0] e_guit;
        logic [2:0] e_inst;
        logic [2:0] e_stb;
        logic       e_bad;
        logic [7:0] e_drop;
    } vec_t;

    vec_t tbl[16];

    // {valid, data} per cycle for the two round-robin scenarios
    logic [8:0] rr1_stim[9];
    logic [8:0] rr2_stim[9];
    logic [2:0] rr1_exp[9];
    logic [2:0] rr2_exp[9];

    note_scheduler #(
        .HOLD_CYCLES (HOLD),
        .TIMER_W     (TIMER_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .bass         (bass),
        .drum         (drum),
        .drum_foot    (drum_foot),
        .guitar       (guitar),
        .inst         (inst),
        .apply_strobe (apply_strobe),
        .bad_id       (bad_id),
        .drop_cnt     (drop_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: apply inputs for one cycle, return 1 time unit after the edge
    task automatic drive(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " bass"},   32'(bass),         32'd0);
        chk({nm, " drum"},   32'(drum),         32'd0);
        chk({nm, " foot"},   32'(drum_foot),    32'd0);
        chk({nm, " guitar"}, 32'(guitar),       32'd0);
        chk({nm, " inst"},   32'(inst),         32'd0);
        chk({nm, " strobe"}, 32'(apply_strobe), 32'd0);
        chk({nm, " bad_id"}, 32'(bad_id),       32'd0);
        chk({nm, " drop"},   32'(drop_cnt),     32'd0);
    endtask

    // scoreboard: expected strobe per cycle popped in order
    task automatic run_rr(input string nm, input logic [8:0] stim[9], input logic [2:0] expv[9]);
        logic [2:0] e;
        for (int i = 0; i < 9; i++) exp_q.push_back(expv[i]);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, stim[i][8], stim[i][7:0]);
            e = exp_q.pop_front();
            chk($sformatf("%s cyc%0d strobe", nm, i + 1), 32'(apply_strobe), 32'(e));
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        //        r     v     data            bass      drum     ft    guit  inst    stb     bad   drop
        tbl[0]  = '{1'b1, 1'b0, 8'h00,          5'd0,     4'd0,    1'b0, 5'd0, 3'b000, 3'b000, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'b01011_001,   5'd0,     4'd0,    1'b0, 5'd0, 3'b000, 3'b000, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00,          5'b01011, 4'd0,    1'b0, 5'd0, 3'b010, 3'b001, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00,          5'b01011, 4'd0,    1'b0, 5'd0, 3'b010, 3'b000, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 1'b1, 8'b10110_010,   5'b01011, 4'd0,    1'b0, 5'd0, 3'b010, 3'b000, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00,          5'b01011, 4'b0110, 1'b1, 5'd0, 3'b110, 3'b010, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 1'b1, 8'b00000_010,   5'b01011, 4'b0110, 1'b1, 5'd0, 3'b110, 3'b000, 1'b0, 8'd0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00,          5'b01011, 4'b0110, 1'b1, 5'd0, 3'b110, 3'b000, 1'b0, 8'd0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00,          5'b01011, 4'b0110, 1'b1, 5'd0, 3'b110, 3'b000, 1'b0, 8'd0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00,          5'b01011, 4'b0110, 1'b1, 5'd0, 3'b110, 3'b000, 1'b0, 8'd0};
        tbl[10] = '{1'b0, 1'b0, 8'h00,          5'b01011, 4'd0,    1'b0, 5'd0, 3'b010, 3'b010, 1'b0, 8'd0};
        tbl[11] = '{1'b0, 1'b1, 8'b11111_011,   5'b01011, 4'd0,    1'b0, 5'd0, 3'b010, 3'b000, 1'b1, 8'd0};
        tbl[12] = '{1'b0, 1'b0, 8'h00,          5'b01011, 4'd0,    1'b0, 5'd0, 3'b010, 3'b000, 1'b0, 8'd0};
        tbl[13] = '{1'b0, 1'b1, 8'h00,          5'b01011, 4'd0,    1'b0, 5'd0, 3'b010, 3'b000, 1'b1, 8'd0};
        tbl[14] = '{1'b0, 1'b1, 8'b10101_111,   5'b01011, 4'd0,    1'b0, 5'd0, 3'b010, 3'b000, 1'b1, 8'd0};
        tbl[15] = '{1'b0, 1'b0, 8'h00,          5'b01011, 4'd0,    1'b0, 5'd0, 3'b010, 3'b000, 1'b0, 8'd0};

        // Phase 1: pointer at bass, bass and drum contend in cycle 7.
        rr1_stim = '{{1'b1, 5'd1, B}, 9'd0, {1'b1, 5'd2, G}, 9'd0, {1'b1, 5'd3, B},
                     {1'b1, 5'd4, D}, {1'b1, 5'd5, G}, 9'd0, 9'd0};
        rr1_exp  = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100};
        // Phase 2: pointer at drum; guitar beats bass in cycle 8 on pointer alone.
        rr2_stim = '{{1'b1, 5'd6, G}, {1'b1, 5'd7, B}, 9'd0, {1'b1, 5'd8, G}, {1'b1, 5'd9, B},
                     {1'b1, 5'd10, D}, 9'd0, 9'd0, 9'd0};
        rr2_exp  = '{3'b000, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b001};

        drive(1'b1, 1'b0, 8'h00);

        // table: bass from idle, drum foot, bad IDs
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].d);
            chk($sformatf("row%0d bass", i),   32'(bass),         32'(tbl[i].e_bass));
            chk($sformatf("row%0d drum", i),   32'(drum),         32'(tbl[i].e_drum));
            chk($sformatf("row%0d foot", i),   32'(drum_foot),    32'(tbl[i].e_foot));
            chk($sformatf("row%0d guitar", i), 32'(guitar),       32'(tbl[i].e_guit));
            chk($sformatf("row%0d inst", i),   32'(inst),         32'(tbl[i].e_inst));
            chk($sformatf("row%0d strobe", i), 32'(apply_strobe), 32'(tbl[i].e_stb));
            chk($sformatf("row%0d bad_id", i), 32'(bad_id),       32'(tbl[i].e_bad));
            chk($sformatf("row%0d drop", i),   32'(drop_cnt),     32'(tbl[i].e_drop));
        end

        // hold window and latest-wins overwrite on guitar
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, {5'd5, G});
        chk("hold accept strobe", 32'(apply_strobe), 32'd0);
        drive(1'b0, 1'b0, 8'h00);
        chk("hold first guitar", 32'(guitar), 32'd5);
        chk("hold first strobe", 32'(apply_strobe), 32'(G));
        chk("hold first inst", 32'(inst), 32'b001);
        drive(1'b0, 1'b1, {5'd9, G});
        chk("hold pend9 drop", 32'(drop_cnt), 32'd0);
        chk("hold pend9 strobe", 32'(apply_strobe), 32'd0);
        drive(1'b0, 1'b1, {5'd12, G});
        chk("hold over12 drop", 32'(drop_cnt), 32'd1);
        chk("hold over12 guitar", 32'(guitar), 32'd5);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 8'h00);
            chk($sformatf("hold wait%0d strobe", k), 32'(apply_strobe), 32'd0);
            chk($sformatf("hold wait%0d guitar", k), 32'(guitar), 32'd5);
        end
        drive(1'b0, 1'b0, 8'h00);
        chk("hold regrant guitar", 32'(guitar), 32'd12);
        chk("hold regrant strobe", 32'(apply_strobe), 32'(G));
        chk("hold regrant drop", 32'(drop_cnt), 32'd1);

        // round robin
        drive(1'b1, 1'b0, 8'h00);
        run_rr("rr1", rr1_stim, rr1_exp);
        chk("rr1 bass", 32'(bass), 32'd3);
        chk("rr1 drum", 32'(drum), 32'd4);
        chk("rr1 guitar", 32'(guitar), 32'd5);
        drive(1'b1, 1'b0, 8'h00);
        run_rr("rr2", rr2_stim, rr2_exp);
        chk("rr2 bass", 32'(bass), 32'd9);
        chk("rr2 drum", 32'(drum), 32'b1010);
        chk("rr2 guitar", 32'(guitar), 32'd8);
        chk("rr2 drop", 32'(drop_cnt), 32'd0);

        // guitar byte every cycle: same-cycle accept+grant, then saturation
        drive(1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 400; k++) begin
            drive(1'b0, 1'b1, {5'(k), G});
            if (k == 2) begin
                chk("sat k2 strobe", 32'(apply_strobe), 32'(G));
                chk("sat k2 guitar", 32'(guitar), 32'd1);
                chk("sat k2 drop", 32'(drop_cnt), 32'd0);
            end
            if (k == 3) chk("sat k3 drop", 32'(drop_cnt), 32'd1);
            if (k == 6) chk("sat k6 drop", 32'(drop_cnt), 32'd4);
            if (k == 7) begin
                chk("sat k7 strobe", 32'(apply_strobe), 32'(G));
                chk("sat k7 guitar", 32'(guitar), 32'd6);
                chk("sat k7 drop", 32'(drop_cnt), 32'd4);
            end
        end
        chk("sat final drop", 32'(drop_cnt), 32'd255);
        drive(1'b0, 1'b1, {5'd1, G});
        chk("sat hold drop", 32'(drop_cnt), 32'd255);

        // reset mid-operation: guitar pending, bass in hold
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        chk_zero("rst1");
        drive(1'b0, 1'b1, {5'd3, G});
        drive(1'b0, 1'b1, {5'd4, B});
        chk("mid guitar grant", 32'(apply_strobe), 32'(G));
        drive(1'b0, 1'b0, 8'h00);
        chk("mid bass grant", 32'(apply_strobe), 32'(B));
        drive(1'b0, 1'b1, {5'd6, G});
        chk("mid guitar pend strobe", 32'(apply_strobe), 32'd0);
        drive(1'b1, 1'b0, 8'h00);
        chk_zero("rst2");
        drive(1'b0, 1'b1, {5'd7, B});
        chk("post rst accept strobe", 32'(apply_strobe), 32'd0);
        chk("post rst guitar", 32'(guitar), 32'd0);
        drive(1'b0, 1'b0, 8'h00);
        chk("post rst bass strobe", 32'(apply_strobe), 32'(B));
        chk("post rst bass", 32'(bass), 32'd7);
        chk("post rst inst", 32'(inst), 32'b010);
        drive(1'b0, 1'b0, 8'h00);
        chk("post rst quiet strobe", 32'(apply_strobe), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
